m_ghr_index: RTL

M_GHR_INDEX -- requirements
Module: m_ghr_index

---
 rtl/m_ghr_index_pkg.sv | 12 +
 rtl/m_ghr_index_ghr.sv | 46 ++++
 rtl/m_ghr_index.sv | 132 +++++++++++++
 3 files changed

// File: rtl/m_ghr_index_pkg.sv
// Shared predictor package.
// Holds the default geometry of the gshare index block and the PC bit where
// the predictor index starts (instructions are word aligned, so PC[1:0]
// carry no information).
package m_ghr_index_pkg;

  localparam int IDX_W_DEF  = 5;   // predictor index width
  localparam int GHR_W_DEF  = 5;   // global-history length
  localparam int CNT_W_DEF  = 16;  // mispredict counter width
  localparam int PC_IDX_LSB = 2;   // lowest PC bit used in the index

endpackage : m_ghr_index_pkg

// File: rtl/m_ghr_index_ghr.sv
// m_ghr -- global-history shift register.
// Shifts left inserting w_in at bit 0 when w_shift is high; a parallel load
// (w_load) wins over a same-cycle shift; w_rst clears it synchronously.
// Ports:
//   w_clk   in   clock (rising edge)
//   w_rst   in   synchronous active-high reset
//   w_shift in   shift-in enable
//   w_in    in   bit shifted in at bit 0
//   w_load  in   parallel-load enable (priority over w_shift)
//   w_ldval in   parallel-load value
//   w_ghr   out  current history
module m_ghr #(
  parameter int W = 5
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic         w_shift,
  input  logic         w_in,
  input  logic         w_load,
  input  logic [W-1:0] w_ldval,
  output logic [W-1:0] w_ghr
);

  logic [W-1:0] ghr_q;
  logic [W-1:0] ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (w_load) begin
      ghr_d = w_ldval;
    end else if (w_shift) begin
      ghr_d = {ghr_q[W-2:0], w_in};
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign w_ghr = ghr_q;

endmodule : m_ghr

// File: rtl/m_ghr_index.sv
// m_ghr_index -- gshare index generation and training control.
// Produces the predictor read index from the fetch PC XOR speculative
// history, carries it two stages to the resolve point, and drives the
// predictor write port. Mispredicts restore the speculative history from
// the architected one, flush the wrong-path entries and bump a saturating
// counter. Port names line up with m_bimodal for direct connection.
// Ports:
//   w_clk, w_rst   clock / synchronous active-high reset
//   w_pc           IF-stage fetch PC
//   w_isbr         IF-stage instruction is a conditional branch
//   w_pred         predictor direction for the current w_radr
//   w_res_v        branch resolved this cycle (2 cycles after its read)
//   w_res_tkn      resolved direction
//   w_res_mis      resolved branch was mispredicted
//   w_radr         predictor read index (combinational)
//   w_wadr, w_we, w_tkn   predictor write port
//   w_miscnt       saturating count of accepted mispredicts
module m_ghr_index
  import m_ghr_index_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int GHR_W = GHR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [31:0]      w_pc,
  input  logic             w_isbr,
  input  logic             w_pred,
  input  logic             w_res_v,
  input  logic             w_res_tkn,
  input  logic             w_res_mis,
  output logic [IDX_W-1:0] w_radr,
  output logic [IDX_W-1:0] w_wadr,
  output logic             w_we,
  output logic             w_tkn,
  output logic [CNT_W-1:0] w_miscnt
);

  logic [GHR_W-1:0] sghr_q;
  logic [GHR_W-1:0] aghr_q;
  logic [IDX_W-1:0] sghr_idx;

  logic [IDX_W-1:0] p1_adr_q, p1_adr_d;
  logic [IDX_W-1:0] p2_adr_q, p2_adr_d;
  logic             p1_v_q, p1_v_d;
  logic             p2_v_q, p2_v_d;
  logic [CNT_W-1:0] miscnt_q, miscnt_d;

  logic accept;   // resolution belongs to a real in-flight branch
  logic mis;      // accepted mispredict

  assign accept = w_res_v & p2_v_q;
  assign mis    = accept & w_res_mis;

  // History is folded into the index bit-for-bit; if the history is shorter
  // than the index the missing upper bits are zero.
  genvar gi;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_idx
      if (gi < GHR_W) begin : g_hist
        assign sghr_idx[gi] = sghr_q[gi];
      end else begin : g_pad
        assign sghr_idx[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_radr = w_pc[PC_IDX_LSB +: IDX_W] ^ sghr_idx;

  // Speculative history: recovery load is the architected history with the
  // resolved direction appended, i.e. exactly what aghr becomes this edge.
  m_ghr #(.W(GHR_W)) u_sghr (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_shift (w_isbr & ~mis),
    .w_in    (w_pred),
    .w_load  (mis),
    .w_ldval ({aghr_q[GHR_W-2:0], w_res_tkn}),
    .w_ghr   (sghr_q)
  );

  m_ghr #(.W(GHR_W)) u_aghr (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_shift (accept),
    .w_in    (w_res_tkn),
    .w_load  (1'b0),
    .w_ldval ('0),
    .w_ghr   (aghr_q)
  );

  // Index pipeline. A mispredict kills everything younger than the
  // resolving branch: the entry sitting in P1 and the branch being fetched.
  always_comb begin
    p1_adr_d = w_radr;
    p1_v_d   = w_isbr & ~mis;
    p2_adr_d = p1_adr_q;
    p2_v_d   = p1_v_q & ~mis;
    miscnt_d = miscnt_q;
    if (mis && (miscnt_q != {CNT_W{1'b1}})) begin
      miscnt_d = miscnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      p1_adr_q <= '0;
      p2_adr_q <= '0;
      p1_v_q   <= 1'b0;
      p2_v_q   <= 1'b0;
      miscnt_q <= '0;
    end else begin
      p1_adr_q <= p1_adr_d;
      p2_adr_q <= p2_adr_d;
      p1_v_q   <= p1_v_d;
      p2_v_q   <= p2_v_d;
      miscnt_q <= miscnt_d;
    end
  end

  assign w_wadr   = p2_adr_q;
  assign w_tkn    = w_res_tkn;
  assign w_we     = accept;
  assign w_miscnt = miscnt_q;

  // PC bits outside the index field and history bits beyond the index are
  // intentionally not part of the read index.
  logic unused_ok;
  assign unused_ok = ^{w_pc, sghr_q, aghr_q};

endmodule : m_ghr_index
